// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the datapath enables
// from the registered state, waits on a variable-latency memory and traps memory timeouts.
// Optional feature: define MCCTRL_ILLEGAL_TRAP_EN to route illegal instructions through a
// TRAP state and expose the IllegalInstr port; otherwise illegal instructions act as NOP.

module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       WriDataSel,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [5:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       InstrDone,
    output logic       MemTimeout
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic       IllegalInstr
`endif
);

    localparam logic [5:0] AluAdd = 6'b100000;
    localparam logic [5:0] AluSub = 6'b100010;
    localparam logic [5:0] AluXor = 6'b100110;
    localparam logic [5:0] AluNop = 6'b101100;

    localparam logic [TO_W-1:0] TimeoutCnt = TO_W'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StError,
        StTrap
    } state_t;

    typedef enum logic [3:0] {
        ClsNop,
        ClsR,
        ClsJr,
        ClsLw,
        ClsSw,
        ClsXori,
        ClsBne,
        ClsJ,
        ClsJal,
        ClsIll
    } cls_t;

    state_t          state_q, state_d;
    cls_t            cls_q, cls_d;
    cls_t            dec_cls;
    logic [5:0]      fn_q, fn_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Classify the instruction currently held in the IR.
    always_comb begin
        dec_cls = ClsIll;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b000000:                       dec_cls = ClsNop;
                    6'b100000, 6'b100010, 6'b101010: dec_cls = ClsR;
                    6'b001000:                       dec_cls = ClsJr;
                    default:                         dec_cls = ClsIll;
                endcase
            end
            6'b100011: dec_cls = ClsLw;
            6'b101011: dec_cls = ClsSw;
            6'b001110: dec_cls = ClsXori;
            6'b000101: dec_cls = ClsBne;
            6'b000010: dec_cls = ClsJ;
            6'b000011: dec_cls = ClsJal;
            default:   dec_cls = ClsIll;
        endcase
    end

    // Next-state logic and per-state datapath controls.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        fn_d       = fn_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        WriDataSel = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = AluNop;
        PCSrc      = 2'b00;
        InstrDone  = 1'b0;
        MemTimeout = 1'b0;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        IllegalInstr = 1'b0;
`endif
        // Outputs stay idle during reset so an abandoned memory write never issues.
        if (!reset) begin
            case (state_q)
                StIdle: state_d = StFetch;
                StFetch: begin
                    MemRead = 1'b1;
                    if (MemReady) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        ALUSrcB = 2'b01;
                        ALUOp   = AluAdd;
                        state_d = StDecode;
                    end else if (cnt_q == TimeoutCnt) begin
                        state_d = StError;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDecode: begin
                    ALUSrcB = 2'b11;
                    ALUOp   = AluAdd;
                    cls_d   = dec_cls;
                    fn_d    = funct;
                    case (dec_cls)
                        ClsNop: begin
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                        ClsIll: begin
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                            state_d = StTrap;
`else
                            InstrDone = 1'b1;
                            state_d   = StFetch;
`endif
                        end
                        default: state_d = StExec;
                    endcase
                end
                StExec: begin
                    case (cls_q)
                        ClsR: begin
                            ALUSrcA = 1'b1;
                            ALUOp   = fn_q;
                            state_d = StWb;
                        end
                        ClsLw, ClsSw: begin
                            ALUSrcA = 1'b1;
                            ALUSrcB = 2'b10;
                            ALUOp   = AluAdd;
                            state_d = StMem;
                        end
                        ClsXori: begin
                            ALUSrcA = 1'b1;
                            ALUSrcB = 2'b10;
                            ALUOp   = AluXor;
                            state_d = StWb;
                        end
                        ClsBne: begin
                            ALUSrcA   = 1'b1;
                            ALUOp     = AluSub;
                            PCSrc     = 2'b01;
                            PCWrite   = ~Zero;
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                        ClsJ: begin
                            PCWrite   = 1'b1;
                            PCSrc     = 2'b10;
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                        ClsJr: begin
                            PCWrite   = 1'b1;
                            PCSrc     = 2'b11;
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                        ClsJal: begin
                            PCWrite   = 1'b1;
                            PCSrc     = 2'b10;
                            RegWrite  = 1'b1;
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                        default: state_d = StFetch;
                    endcase
                end
                StMem: begin
                    // Keep the address computation on the ALU while the access is pending.
                    IorD     = 1'b1;
                    ALUSrcA  = 1'b1;
                    ALUSrcB  = 2'b10;
                    ALUOp    = AluAdd;
                    MemRead  = (cls_q == ClsLw);
                    MemWrite = (cls_q == ClsSw);
                    if (MemReady) begin
                        if (cls_q == ClsLw) begin
                            state_d = StWb;
                        end else begin
                            InstrDone = 1'b1;
                            state_d   = StFetch;
                        end
                    end else if (cnt_q == TimeoutCnt) begin
                        state_d = StError;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWb: begin
                    RegWrite   = 1'b1;
                    WriDataSel = 1'b1;
                    RegDst     = (cls_q == ClsR);
                    MemtoReg   = (cls_q == ClsLw);
                    InstrDone  = 1'b1;
                    state_d    = StFetch;
                end
                StError: MemTimeout = 1'b1;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                StTrap: begin
                    IllegalInstr = 1'b1;
                    InstrDone    = 1'b1;
                    state_d      = StFetch;
                end
`endif
                default: state_d = StIdle;
            endcase
            // Every state change starts a fresh wait window.
            if (state_d != state_q) begin
                cnt_d = '0;
            end
        end
    end

    // State, decode latches and wait counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cls_q   <= ClsNop;
            fn_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            fn_q    <= fn_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: self-checking bench for multicycle_control.
// An instruction-level model expands each instruction into its expected per-cycle control
// vector; directed and random instructions with random memory latencies are replayed.

module tb_multicycle_control;

    localparam int TimeoutLim = 15;
    localparam logic [5:0] AluAdd = 6'b100000;
    localparam logic [5:0] AluSub = 6'b100010;
    localparam logic [5:0] AluXor = 6'b100110;
    localparam logic [5:0] AluNop = 6'b101100;
    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpXori = 6'b001110;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam logic [5:0] OpJal  = 6'b000011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
    logic       WriDataSel, ALUSrcA, InstrDone, MemTimeout;
    logic [1:0] ALUSrcB, PCSrc;
    logic [5:0] ALUOp;
    logic       obs_ill;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    logic IllegalInstr;
    localparam bit TrapEn = 1'b1;
    assign obs_ill = IllegalInstr;
`else
    localparam bit TrapEn = 1'b0;
    assign obs_ill = 1'b0;
`endif

    multicycle_control #(.MEM_TIMEOUT(TimeoutLim), .TO_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .WriDataSel (WriDataSel),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .InstrDone  (InstrDone),
        .MemTimeout (MemTimeout)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        ,
        .IllegalInstr (IllegalInstr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, irw, iord, mrd, mwr, rgw, rdst, m2r, wds, asa;
        logic [1:0] asb;
        logic [5:0] aluop;
        logic [1:0] pcsrc;
        logic       done, tmo;
    } ctl_t;

    typedef struct packed {
        logic       rst, ready, zero;
        logic [5:0] op, fn;
        ctl_t       exp;
        logic       ill;
    } rec_t;

    typedef enum {KNop, KR, KJr, KLw, KSw, KXori, KBne, KJ, KJal, KIll} kind_t;

    ctl_t obs;
    assign obs = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst, MemtoReg,
                  WriDataSel, ALUSrcA, ALUSrcB, ALUOp, PCSrc, InstrDone, MemTimeout};

    rec_t q[$];
    rec_t r;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = KIll;
        case (op)
            OpR: begin
                if (fn == 6'b000000) k = KNop;
                else if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b101010) k = KR;
                else if (fn == 6'b001000) k = KJr;
            end
            OpLw:    k = KLw;
            OpSw:    k = KSw;
            OpXori:  k = KXori;
            OpBne:   k = KBne;
            OpJ:     k = KJ;
            OpJal:   k = KJal;
            default: k = KIll;
        endcase
        return k;
    endfunction

    function automatic ctl_t base();
        ctl_t c;
        c = '0;
        c.aluop = AluNop;
        return c;
    endfunction

    task automatic push(input logic rst, input logic ready, input logic zero,
                        input logic [5:0] op, input logic [5:0] fn, input ctl_t c,
                        input logic ill);
        rec_t x;
        x.rst = rst; x.ready = ready; x.zero = zero; x.op = op; x.fn = fn;
        x.exp = c; x.ill = ill;
        q.push_back(x);
    endtask

    // n reset cycles, then the single idle cycle before fetch starts.
    task automatic model_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, '0, base(), 1'b0);
        push(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0, base(), 1'b0);
    endtask

    // Latency above the limit means memory never answers in that phase.
    task automatic model_hang(input logic zero, input logic [5:0] op, input logic [5:0] fn,
                              input ctl_t wait_v);
        ctl_t c;
        for (int i = 0; i <= TimeoutLim; i++) push(1'b0, 1'b0, zero, op, fn, wait_v, 1'b0);
        c = base();
        c.tmo = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b0);
    endtask

    task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                               input int flat, input int mlat);
        kind_t k;
        ctl_t  c, mv;
        k = classify(op, fn);
        c = base();
        c.mrd = 1'b1;
        if (flat > TimeoutLim) begin
            model_hang(zero, op, fn, c);
            return;
        end
        for (int i = 0; i < flat; i++) push(1'b0, 1'b0, zero, op, fn, c, 1'b0);
        c.irw = 1'b1; c.pcw = 1'b1; c.asb = 2'b01; c.aluop = AluAdd;
        push(1'b0, 1'b1, zero, op, fn, c, 1'b0);
        c = base();
        c.asb = 2'b11; c.aluop = AluAdd;
        if (k == KNop || (k == KIll && !TrapEn)) begin
            c.done = 1'b1;
            push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b0);
            return;
        end
        push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b0);
        if (k == KIll) begin
            c = base();
            c.done = 1'b1;
            push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b1);
            return;
        end
        c = base();
        case (k)
            KR:        begin c.asa = 1'b1; c.aluop = fn; end
            KLw, KSw:  begin c.asa = 1'b1; c.asb = 2'b10; c.aluop = AluAdd; end
            KXori:     begin c.asa = 1'b1; c.asb = 2'b10; c.aluop = AluXor; end
            KBne:      begin c.asa = 1'b1; c.aluop = AluSub; c.pcsrc = 2'b01;
                             c.pcw = ~zero; c.done = 1'b1; end
            KJ:        begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.done = 1'b1; end
            KJr:       begin c.pcw = 1'b1; c.pcsrc = 2'b11; c.done = 1'b1; end
            KJal:      begin c.pcw = 1'b1; c.pcsrc = 2'b10; c.rgw = 1'b1; c.done = 1'b1; end
            default:   c = base();
        endcase
        push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b0);
        if (k == KLw || k == KSw) begin
            mv = base();
            mv.iord = 1'b1; mv.asa = 1'b1; mv.asb = 2'b10; mv.aluop = AluAdd;
            mv.mrd = (k == KLw); mv.mwr = (k == KSw);
            if (mlat > TimeoutLim) begin
                model_hang(zero, op, fn, mv);
                return;
            end
            for (int i = 0; i < mlat; i++) push(1'b0, 1'b0, zero, op, fn, mv, 1'b0);
            mv.done = (k == KSw);
            push(1'b0, 1'b1, zero, op, fn, mv, 1'b0);
        end
        if (k == KR || k == KXori || k == KLw) begin
            c = base();
            c.rgw = 1'b1; c.wds = 1'b1; c.rdst = (k == KR); c.m2r = (k == KLw); c.done = 1'b1;
            push(1'b0, 1'($urandom_range(0, 1)), zero, op, fn, c, 1'b0);
        end
    endtask

    task automatic apply_rec(input rec_t x);
        reset = x.rst; MemReady = x.ready; Zero = x.zero; opcode = x.op; funct = x.fn;
    endtask

    task automatic test_reset();
        model_reset(3);
        while (q.size() > 0) begin
            r = q.pop_front();
            apply_rec(r);
            @(negedge clk);
            checks++;
            if ({obs, obs_ill} !== {r.exp, r.ill}) begin
                errors++;
                $display("FAIL reset cyc %0d: got %h want %h", cyc, {obs, obs_ill}, {r.exp, r.ill});
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_instructions();
        logic [5:0] ops [11] = '{OpLw, OpSw, OpR, OpR, OpR, OpXori, OpBne, OpJ, OpR, OpJal, OpR};
        logic [5:0] fns [11] = '{6'h15, 6'h2a, 6'b100000, 6'b100010, 6'b101010, 6'h01, 6'h00,
                                 6'h3f, 6'b001000, 6'h11, 6'b000000};
        // Directed set with the two-cycle memory latency, then both BNE outcomes.
        for (int i = 0; i < 11; i++) model_instr(ops[i], fns[i], 1'b0, 2, 2);
        model_instr(OpBne, 6'h05, 1'b1, 0, 0);
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 10);
            model_instr(ops[sel], fns[sel], 1'($urandom_range(0, 1)),
                        $urandom_range(0, TimeoutLim), $urandom_range(0, TimeoutLim));
        end
        while (q.size() > 0) begin
            r = q.pop_front();
            apply_rec(r);
            @(negedge clk);
            checks++;
            if ({obs, obs_ill} !== {r.exp, r.ill}) begin
                errors++;
                $display("FAIL instr op=%b fn=%b cyc %0d: got %h want %h", r.op, r.fn, cyc,
                         {obs, obs_ill}, {r.exp, r.ill});
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        model_instr(OpLw, 6'h00, 1'b0, TimeoutLim, TimeoutLim);
        model_instr(OpSw, 6'h00, 1'b0, TimeoutLim + 1, 0);
        model_reset(1);
        model_instr(OpLw, 6'h00, 1'b0, 0, TimeoutLim + 1);
        model_reset(2);
        model_instr(OpSw, 6'h00, 1'b0, 1, TimeoutLim);
        while (q.size() > 0) begin
            r = q.pop_front();
            apply_rec(r);
            @(negedge clk);
            checks++;
            if ({obs, obs_ill} !== {r.exp, r.ill}) begin
                errors++;
                $display("FAIL timeout cyc %0d: got %h want %h", cyc, {obs, obs_ill},
                         {r.exp, r.ill});
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mem();
        ctl_t c;
        c = base();
        c.mrd = 1'b1; c.irw = 1'b1; c.pcw = 1'b1; c.asb = 2'b01; c.aluop = AluAdd;
        push(1'b0, 1'b1, 1'b0, OpSw, '0, c, 1'b0);
        c = base();
        c.asb = 2'b11; c.aluop = AluAdd;
        push(1'b0, 1'b0, 1'b0, OpSw, '0, c, 1'b0);
        c = base();
        c.asa = 1'b1; c.asb = 2'b10; c.aluop = AluAdd;
        push(1'b0, 1'b0, 1'b0, OpSw, '0, c, 1'b0);
        c.iord = 1'b1; c.mwr = 1'b1;
        push(1'b0, 1'b0, 1'b0, OpSw, '0, c, 1'b0);
        // Reset lands while the store is still pending; nothing may be written.
        push(1'b1, 1'b1, 1'b0, OpSw, '0, base(), 1'b0);
        push(1'b0, 1'b0, 1'b0, OpSw, '0, base(), 1'b0);
        model_instr(OpXori, 6'h00, 1'b0, 3, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            apply_rec(r);
            @(negedge clk);
            checks++;
            if ({obs, obs_ill} !== {r.exp, r.ill}) begin
                errors++;
                $display("FAIL reset_mid_mem cyc %0d: got %h want %h", cyc, {obs, obs_ill},
                         {r.exp, r.ill});
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        model_instr(6'b111111, 6'h2a, 1'b0, 1, 0);
        model_instr(OpR, 6'b000001, 1'b0, 0, 0);
        model_instr(OpLw, 6'h00, 1'b0, 0, 1);
        model_instr(6'b010000, 6'h00, 1'b1, 2, 0);
        model_instr(OpR, 6'b100000, 1'b0, 0, 0);
        while (q.size() > 0) begin
            r = q.pop_front();
            apply_rec(r);
            @(negedge clk);
            checks++;
            if ({obs, obs_ill} !== {r.exp, r.ill}) begin
                errors++;
                $display("FAIL illegal op=%b cyc %0d: got %h want %h", r.op, cyc,
                         {obs, obs_ill}, {r.exp, r.ill});
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_instructions();
        test_timeout();
        test_reset_mid_mem();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
